// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants, ALU op encodings and instruction decode for
//               the ALU operand/issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_NREG    = 8;
    localparam int c_W       = 16;
    localparam int c_RIDX_W  = 3;
    localparam int c_CTL_W   = 3;
    localparam int c_SHIFT_W = 4;

    localparam int c_CTL_LSB   = 13;
    localparam int c_RD_LSB    = 10;
    localparam int c_RS1_LSB   = 7;
    localparam int c_RS2_LSB   = 4;
    localparam int c_SHIFT_LSB = 0;

    typedef enum logic [c_CTL_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [c_CTL_W-1:0]   ctl;
        logic [c_RIDX_W-1:0]  rd;
        logic [c_RIDX_W-1:0]  rs1;
        logic [c_RIDX_W-1:0]  rs2;
        logic [c_SHIFT_W-1:0] shift;
    } instr_t;

    function automatic instr_t decode_instr(input logic [15:0] i_word);
        instr_t d;
        d.ctl   = i_word[c_CTL_LSB   +: c_CTL_W];
        d.rd    = i_word[c_RD_LSB    +: c_RIDX_W];
        d.rs1   = i_word[c_RS1_LSB   +: c_RIDX_W];
        d.rs2   = i_word[c_RS2_LSB   +: c_RIDX_W];
        d.shift = i_word[c_SHIFT_LSB +: c_SHIFT_W];
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : Register file, 2 combinational read ports with writeback
//               bypass, 1 write port; r0 reads as zero and is never written.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREG = c_NREG,
    parameter int W    = c_W,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [W-1:0]  o_rdata_a,
    output logic [W-1:0]  o_rdata_b
);

    logic [W-1:0] r_regs [NREG];
    logic         w_byp_a;
    logic         w_byp_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Same-cycle writeback forwards straight to the reader.
    assign w_byp_a = i_we && (i_waddr == i_raddr_a);
    assign w_byp_b = i_we && (i_waddr == i_raddr_b);

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : (w_byp_a ? i_wdata : r_regs[i_raddr_a]);
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : (w_byp_b ? i_wdata : r_regs[i_raddr_b]);

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Issue stage ahead of the 16-bit ALU: decode, operand fetch,
//               pending-write scoreboard and a one-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int NREG = c_NREG,
    parameter int W    = c_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic [15:0]          IN_INSTR,
    output logic                 IN_READY,
    output logic [W-1:0]         ALU_DA,
    output logic [W-1:0]         ALU_DB,
    output logic [c_CTL_W-1:0]   ALU_CTL,
    output logic [c_SHIFT_W-1:0] ALU_SHIFT,
    output logic [c_RIDX_W-1:0]  OUT_RD,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    input  logic                 WB_EN,
    input  logic [c_RIDX_W-1:0]  WB_RD,
    input  logic [W-1:0]         WB_DATA
);

    instr_t                w_instr;
    logic [W-1:0]          w_opa;
    logic [W-1:0]          w_opb;
    logic [NREG-1:0]       r_pend;
    logic [NREG-1:0]       w_clr;
    logic [NREG-1:0]       w_set;
    logic [NREG-1:0]       w_live;
    logic [NREG-1:0]       w_pend_nxt;
    logic                  w_hazard;
    logic                  w_accept;

    logic [W-1:0]          r_da;
    logic [W-1:0]          r_db;
    logic [c_CTL_W-1:0]    r_ctl;
    logic [c_SHIFT_W-1:0]  r_shift;
    logic [c_RIDX_W-1:0]   r_rd;
    logic                  r_valid;

    assign w_instr = decode_instr(IN_INSTR);

    alu_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk       (CLK),
        .rst       (RST),
        .i_we      (WB_EN),
        .i_waddr   (WB_RD),
        .i_wdata   (WB_DATA),
        .i_raddr_a (w_instr.rs1),
        .i_raddr_b (w_instr.rs2),
        .o_rdata_a (w_opa),
        .o_rdata_b (w_opb)
    );

    // A pending bit being retired this cycle no longer blocks issue.
    assign w_clr    = WB_EN ? (NREG'(1) << WB_RD) : '0;
    assign w_live   = r_pend & ~w_clr;
    assign w_hazard = w_live[w_instr.rs1] | w_live[w_instr.rs2] | w_live[w_instr.rd];

    assign IN_READY = !RST && !w_hazard && (!r_valid || OUT_READY);
    assign w_accept = IN_VALID && IN_READY;

    // Set is applied after clear so a same-index set wins.
    assign w_set      = (w_accept && (w_instr.rd != '0)) ? (NREG'(1) << w_instr.rd) : '0;
    assign w_pend_nxt = ((r_pend & ~w_clr) | w_set) & ~NREG'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_da    <= '0;
            r_db    <= '0;
            r_ctl   <= '0;
            r_shift <= '0;
            r_rd    <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_da    <= w_opa;
                r_db    <= w_opb;
                r_ctl   <= w_instr.ctl;
                r_shift <= w_instr.shift;
                r_rd    <= w_instr.rd;
            end else if (OUT_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ALU_DA    = r_da;
    assign ALU_DB    = r_db;
    assign ALU_CTL   = r_ctl;
    assign ALU_SHIFT = r_shift;
    assign OUT_RD    = r_rd;
    assign OUT_VALID = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Directed, table-driven self-checking bench for alu_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic [15:0] IN_INSTR;
    logic        IN_READY;
    logic [15:0] ALU_DA;
    logic [15:0] ALU_DB;
    logic [2:0]  ALU_CTL;
    logic [3:0]  ALU_SHIFT;
    logic [2:0]  OUT_RD;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        WB_EN;
    logic [2:0]  WB_RD;
    logic [15:0] WB_DATA;

    int n_vec = 0;
    int n_err = 0;

    alu_operand_stage dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_INSTR  (IN_INSTR),
        .IN_READY  (IN_READY),
        .ALU_DA    (ALU_DA),
        .ALU_DB    (ALU_DB),
        .ALU_CTL   (ALU_CTL),
        .ALU_SHIFT (ALU_SHIFT),
        .OUT_RD    (OUT_RD),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .WB_EN     (WB_EN),
        .WB_RD     (WB_RD),
        .WB_DATA   (WB_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wb_en;
        logic [2:0]  wb_rd;
        logic [15:0] wb_data;
        logic        in_valid;
        logic [15:0] instr;
        logic        exp_ready;
        logic        exp_valid;
        logic        chk_data;
        logic [15:0] exp_da;
        logic [15:0] exp_db;
        logic [2:0]  exp_ctl;
        logic [3:0]  exp_shift;
        logic [2:0]  exp_rd;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [15:0] ins(input logic [2:0] ctl, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [3:0] sh);
        return {ctl, rd, rs1, rs2, sh};
    endfunction

    function automatic vec_t mk(input logic wb_en, input logic [2:0] wb_rd, input logic [15:0] wb_data,
                                input logic in_valid, input logic [15:0] instr,
                                input logic exp_ready, input logic exp_valid, input logic chk_data,
                                input logic [15:0] da, input logic [15:0] db,
                                input logic [2:0] ctl, input logic [3:0] sh, input logic [2:0] rd);
        vec_t v;
        v.wb_en = wb_en;  v.wb_rd = wb_rd;  v.wb_data = wb_data;
        v.in_valid = in_valid;  v.instr = instr;
        v.exp_ready = exp_ready;  v.exp_valid = exp_valid;  v.chk_data = chk_data;
        v.exp_da = da;  v.exp_db = db;  v.exp_ctl = ctl;  v.exp_shift = sh;  v.exp_rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [15:0] da, input logic [15:0] db,
                           input logic [2:0] ctl, input logic [3:0] sh, input logic [2:0] rd);
        chk({name, ".valid"}, OUT_VALID, 1);
        chk({name, ".da"}, ALU_DA, da);
        chk({name, ".db"}, ALU_DB, db);
        chk({name, ".ctl"}, ALU_CTL, ctl);
        chk({name, ".shift"}, ALU_SHIFT, sh);
        chk({name, ".rd"}, OUT_RD, rd);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Vectors run back-to-back with OUT_READY=1 after reset and r-file sweep.
        tbl[0] = mk(1, 3'd1, 16'd51,    0, 16'h0000,             1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 3'd2, 16'd59,    0, 16'h0000,             1, 0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 3'd0, 16'h0000,  1, ins(0, 3, 1, 2, 0),   1, 1, 1, 16'd51, 16'd59, 0, 0, 3);
        tbl[3] = mk(0, 3'd0, 16'h0000,  1, ins(1, 4, 1, 2, 5),   1, 1, 1, 16'd51, 16'd59, 1, 5, 4);
        tbl[4] = mk(1, 3'd3, 16'h1234,  1, ins(2, 5, 3, 1, 0),   1, 1, 1, 16'h1234, 16'd51, 2, 0, 5);
        tbl[5] = mk(1, 3'd4, 16'h00ff,  1, ins(3, 6, 2, 4, 9),   1, 1, 1, 16'd59, 16'h00ff, 3, 9, 6);
        tbl[6] = mk(0, 3'd0, 16'h0000,  1, ins(4, 1, 3, 4, 15),  1, 1, 1, 16'h1234, 16'h00ff, 4, 15, 1);
        tbl[7] = mk(1, 3'd5, 16'h0505,  0, 16'h0000,             1, 0, 0, 0, 0, 0, 0, 0);
        tbl[8] = mk(1, 3'd6, 16'h0606,  0, 16'h0000,             1, 0, 0, 0, 0, 0, 0, 0);
        tbl[9] = mk(1, 3'd1, 16'h0001,  0, 16'h0000,             1, 0, 0, 0, 0, 0, 0, 0);

        // Reset with traffic on both input ports.
        RST = 1; IN_VALID = 1; IN_INSTR = ins(1, 1, 1, 1, 3); OUT_READY = 1;
        WB_EN = 1; WB_RD = 3'd1; WB_DATA = 16'habcd;
        #1;
        chk("rst.in_ready", IN_READY, 0);
        tick();
        tick();
        chk("rst.in_ready2", IN_READY, 0);
        chk("rst.valid", OUT_VALID, 0);
        chk("rst.da", ALU_DA, 0);
        chk("rst.db", ALU_DB, 0);
        chk("rst.ctl", ALU_CTL, 0);
        chk("rst.shift", ALU_SHIFT, 0);
        chk("rst.rd", OUT_RD, 0);
        RST = 0; WB_EN = 0;

        for (int k = 1; k < 8; k++) begin
            IN_INSTR = ins(0, 0, 3'(k), 3'(k), 0);
            tick();
            chk("rfzero.da", ALU_DA, 0);
            chk("rfzero.db", ALU_DB, 0);
        end

        for (int i = 0; i < 10; i++) begin
            WB_EN = tbl[i].wb_en; WB_RD = tbl[i].wb_rd; WB_DATA = tbl[i].wb_data;
            IN_VALID = tbl[i].in_valid; IN_INSTR = tbl[i].instr; OUT_READY = 1;
            #1;
            chk($sformatf("vec%0d.in_ready", i), IN_READY, tbl[i].exp_ready);
            tick();
            chk($sformatf("vec%0d.valid", i), OUT_VALID, tbl[i].exp_valid);
            if (tbl[i].chk_data) begin
                chk_out($sformatf("vec%0d", i), tbl[i].exp_da, tbl[i].exp_db,
                        tbl[i].exp_ctl, tbl[i].exp_shift, tbl[i].exp_rd);
            end
        end
        WB_EN = 0;

        // RAW stall, then same-cycle bypass release.
        IN_VALID = 1; IN_INSTR = ins(5, 3, 1, 0, 0);
        tick();
        chk_out("raw.prod", 16'h0001, 16'h0000, 5, 0, 3);
        IN_INSTR = ins(0, 2, 3, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("raw.stall", IN_READY, 0);
            tick();
        end
        chk("raw.drained", OUT_VALID, 0);
        WB_EN = 1; WB_RD = 3'd3; WB_DATA = 16'h00f0;
        #1;
        chk("raw.release", IN_READY, 1);
        tick();
        chk_out("raw.cons", 16'h00f0, 16'h0000, 0, 0, 2);
        WB_EN = 0; IN_VALID = 0;
        tick();
        WB_EN = 1; WB_RD = 3'd2; WB_DATA = 16'h2222;
        tick();
        WB_EN = 0;

        // Back-pressure with three queued ops.
        OUT_READY = 0; IN_VALID = 1; IN_INSTR = ins(1, 0, 1, 2, 1);
        #1;
        chk("bp.a_ready", IN_READY, 1);
        tick();
        chk_out("bp.a", 16'h0001, 16'h2222, 1, 1, 0);
        IN_INSTR = ins(2, 0, 3, 4, 2);
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp.blocked", IN_READY, 0);
            tick();
            chk_out("bp.hold", 16'h0001, 16'h2222, 1, 1, 0);
        end
        OUT_READY = 1;
        #1;
        chk("bp.b_ready", IN_READY, 1);
        tick();
        chk_out("bp.b", 16'h00f0, 16'h00ff, 2, 2, 0);
        IN_INSTR = ins(3, 0, 5, 6, 3);
        tick();
        chk_out("bp.c", 16'h0505, 16'h0606, 3, 3, 0);
        IN_VALID = 0;
        tick();
        chk("bp.empty", OUT_VALID, 0);

        // r0 write is dropped and never bypassed.
        WB_EN = 1; WB_RD = 3'd0; WB_DATA = 16'hfff0;
        IN_VALID = 1; IN_INSTR = ins(0, 0, 0, 0, 0);
        tick();
        chk("r0.byp_da", ALU_DA, 0);
        chk("r0.byp_db", ALU_DB, 0);
        WB_EN = 0;
        tick();
        chk("r0.read", ALU_DA, 0);

        // Set and clear of pend[5] in the same cycle: set wins.
        WB_EN = 1; WB_RD = 3'd5; WB_DATA = 16'h5555; IN_INSTR = ins(6, 5, 1, 1, 0);
        #1;
        chk("sw.ready", IN_READY, 1);
        tick();
        chk_out("sw.issue", 16'h0001, 16'h0001, 6, 0, 5);
        WB_EN = 0; IN_INSTR = ins(7, 0, 5, 0, 0);
        #1;
        chk("sw.pend5", IN_READY, 0);
        tick();
        chk("sw.drain", OUT_VALID, 0);
        WB_EN = 1; WB_RD = 3'd5; WB_DATA = 16'h5a5a;
        #1;
        chk("sw.release", IN_READY, 1);
        tick();
        chk_out("sw.cons", 16'h5a5a, 16'h0000, 7, 0, 0);
        WB_EN = 0; IN_VALID = 0;
        tick();

        // Reset while an op is held and pend[4] is set.
        OUT_READY = 0; IN_VALID = 1; IN_INSTR = ins(4, 4, 1, 0, 6);
        tick();
        chk_out("mf.held", 16'h0001, 16'h0000, 4, 6, 4);
        OUT_READY = 1; IN_INSTR = ins(0, 0, 4, 0, 0);
        #1;
        chk("mf.pend4", IN_READY, 0);
        RST = 1; WB_EN = 1; WB_RD = 3'd4; WB_DATA = 16'h4444;
        #1;
        chk("mf.rst_ready", IN_READY, 0);
        tick();
        chk("mf.valid", OUT_VALID, 0);
        chk("mf.da", ALU_DA, 0);
        chk("mf.ctl", ALU_CTL, 0);
        chk("mf.shift", ALU_SHIFT, 0);
        chk("mf.rd", OUT_RD, 0);
        RST = 0; WB_EN = 0;
        #1;
        chk("mf.ready", IN_READY, 1);
        tick();
        chk_out("mf.issue", 16'h0000, 16'h0000, 0, 0, 0);
        WB_EN = 1; WB_RD = 3'd4; WB_DATA = 16'h4444;
        #1;
        chk("mf.stray_ready", IN_READY, 1);
        tick();
        chk_out("mf.stray", 16'h4444, 16'h0000, 0, 0, 0);
        WB_EN = 0; IN_VALID = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Issue stage directly upstream of the 16-bit ALU. Holds an 8×16-bit register file, decodes a 16-bit instruction word into the ALU operands `ALU_DA`/`ALU_DB`, the op select `ALU_CTL` and the shift amount `ALU_SHIFT`, and presents them from a one-entry output register under a valid/ready handshake. A pending-write scoreboard stalls issue on RAW/WAW hazards until the ALU result returns on the writeback port.

## Interface
- `NREG`, 8: register count; r0 reads as 0 and is never written.
- `W`, 16: data width.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `IN_VALID` in 1: instruction word valid.
- `IN_INSTR` in 16: fields are `[15:13]` ctl, `[12:10]` rd, `[9:7]` rs1, `[6:4]` rs2, `[3:0]` shift.
- `IN_READY` out 1: instruction accepted when `IN_VALID & IN_READY`.
- `ALU_DA` out 16: operand A (value of rs1).
- `ALU_DB` out 16: operand B (value of rs2).
- `ALU_CTL` out 3: ALU op.
- `ALU_SHIFT` out 4: shift amount.
- `OUT_RD` out 3: destination register, carried with the op.
- `OUT_VALID` out 1: output register holds an op.
- `OUT_READY` in 1: downstream consumes when `OUT_VALID & OUT_READY`.
- `WB_EN` in 1: writeback strobe.
- `WB_RD` in 3: writeback register.
- `WB_DATA` in 16: writeback value (`ALU_DC`).

## Operation
- Register file: write on `WB_EN & WB_RD!=0` at the clock edge. Reads are combinational.
- Bypass: if `WB_EN` and `WB_RD` equals rs1 or rs2 (non-zero) in the issue cycle, that operand takes `WB_DATA`.
- Scoreboard `pend[7:0]`, with `pend[0]` tied to 0.
  - Set bit rd on accept when rd≠0.
  - Clear bit `WB_RD` on `WB_EN`.
  - If a set and a clear hit the same index in the same cycle, the set wins.
- Hazard on the current `IN_INSTR`: rs1, rs2 or rd has its pend bit set, and that bit is not being cleared by a `WB_EN`/`WB_RD` match this cycle.
- `IN_READY = !RST & !hazard & (!OUT_VALID | OUT_READY)`.
- On accept, the output register loads the decoded fields and the bypassed operands, and `OUT_VALID` is set to 1.
- On consume without accept, `OUT_VALID` goes to 0. Consume and accept in the same cycle reloads the register back-to-back.
- While `OUT_VALID & !OUT_READY`, all outputs are held stable.
- `WB_EN` with a `WB_RD` whose pend bit is clear is legal: the register is written and `pend` is unchanged.

## Timing
- Accept at edge N: `ALU_*`, `OUT_RD` and `OUT_VALID` are updated after edge N, so latency is 1 cycle.
- Throughput: 1 op per cycle when hazard-free and `OUT_READY=1`.
- A dependent instruction issues in the same cycle its producer's `WB_EN` arrives, using the bypass. There is no extra bubble.
- Reset, including reset mid-operation:
  - All registers = 0, `pend` = 0, `OUT_VALID` = 0.
  - `ALU_DA`, `ALU_DB`, `ALU_CTL`, `ALU_SHIFT` and `OUT_RD` = 0.
  - `IN_READY` = 0 during reset.
  - `WB_EN` during reset is ignored.
  - In-flight ops are discarded. Writebacks arriving after reset deassertion are treated as legal stray writes.

## Structure
- Shared package `alu_pkg`:
  - ALU op encodings (`ALU_CTL` values).
  - Instruction field bit positions.
  - `NREG` and `W`.
- One sub-module, `alu_regfile`: 2 combinational read ports, 1 write port, r0 hardwired to 0, bypass mux inside.
- Scoreboard, handshake and output register live in the top module.

## Test plan
- **Reset:** assert `RST` for 2 cycles while `IN_VALID=1` and `WB_EN=1` → all outputs 0, `IN_READY=0`; afterwards r1..r7 read 0.
- **Basic issue:**
  - Step 1: WB writes r1=51, then r2=59.
  - Step 2: issue ctl=000, rd=3, rs1=1, rs2=2, shift=0.
  - Required: next cycle `ALU_DA=51`, `ALU_DB=59`, `ALU_CTL=000`, `OUT_RD=3`, `OUT_VALID=1`.
- **RAW stall:**
  - Issue rd=3, then rs1=3 with no WB → `IN_READY=0` for as long as WB is withheld.
  - Then `WB_EN`, rd=3, `WB_DATA=16'h00f0` → accepted that same cycle with `ALU_DA=16'h00f0`.
- **Back-pressure:** hold `OUT_READY=0` with 3 ops offered → first op held stable, `IN_READY=0`. Release → one op consumed per cycle, in order.
- **r0 and set-wins:**
  - `WB_EN` with rd=0, data `16'hfff0` → r0 still reads 0.
  - Same cycle: issue rd=5 while WB writes r5 → `pend[5]=1` afterwards.
- **Reset mid-flight:** `pend[4]=1` and `OUT_VALID=1`, then pulse `RST` → `pend=0`, `OUT_VALID=0`, and an rs1=4 instruction is accepted immediately.
